crossbar4x4_sched: RTL and testbench
====================================

// Module: crossbar4x4_sched
// PURPOSE
//   Round-robin scheduler for the 4x4 crossbar. Four input requesters each name one destination
//   output; per output, one requester wins and holds the path for a fixed-length burst. Drives
//   the crossbar sel1..sel4 directly and gives each requester a per-beat ready/last handshake.
// PARAMETERS
//   BURST_LEN  4  beats per granted burst, legal 1..256 (8-bit beat counter per output)
// PORTS
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  reset, asynchronous, active-high
//   req_vld    in   4  bit i: input i requests a burst
//   req_dst    in   8  [2i+1:2i]: destination output of input i (0..3 = out1..out4)
//   out_rdy    in   4  bit j: output j sink accepts a beat this cycle
//   sel1..sel4 out  2  each: crossbar select for out1..out4 (value = owning input index)
//   out_vld    out  4  bit j: output j busy, sel_j path carries valid data
//   in_rdy     out  4  bit i: beat from input i transferred this cycle
//   in_last    out  4  bit i: this in_rdy beat is the final beat of input i's burst
//   in_gnt     out  4  bit i: input i owns an output (held for whole burst)
// BEHAVIOUR
// - Per output j: FSM IDLE/BUSY, beat counter cnt_j (8b), RR pointer ptr_j (2b), owner own_j (2b).
// - Reset: all FSMs IDLE, cnt=0, ptr=0, own=0; sel1..sel4=0; out_vld, in_rdy, in_last, in_gnt=0.
// - Eligible(i,j) = req_vld[i] & req_dst_i==j & ~in_gnt[i]. Inputs already owning an output
//   are masked (req_dst changes while granted are ignored).
// - IDLE j with >=1 eligible input: winner = first eligible scanning ptr_j, ptr_j+1, ... mod 4.
//   Next edge: BUSY, own_j<=winner, cnt_j<=0, ptr_j<=winner+1 (mod 4). Arbitration does not
//   depend on out_rdy. One-cycle arbitration latency: req_vld high in cycle t -> grant cycle t+1.
// - Outputs j arbitrate independently and in parallel; distinct destinations never conflict
//   since each input names one destination and owners are masked.
// - sel_j = own_j (registered); holds last owner while IDLE. out_vld[j] = (state_j==BUSY).
// - in_gnt[i] = OR_j(BUSY_j & own_j==i); in_rdy[i] = OR_j(BUSY_j & own_j==i & out_rdy[j]);
//   in_last[i] = in_rdy[i] & cnt_j==BURST_LEN-1. All combinational from registered state + out_rdy.
// - BUSY j: beat counts only when out_rdy[j]=1 (cnt_j++); out_rdy=0 stalls, nothing changes.
//   Beat with cnt_j==BURST_LEN-1 and out_rdy=1 -> IDLE next edge, cnt_j<=0.
// - Mandatory one IDLE bubble cycle per output between bursts; arbitration happens in that cycle.
//   Requester wanting no further burst deasserts req_vld no later than the cycle after in_last.
// - BURST_LEN=1: every grant is a single beat; in_last==in_rdy.
// - req_vld dropping mid-burst: ignored, burst runs to BURST_LEN beats (requester owns data).
// - rst mid-burst: immediate abort, all state to reset values; no partial-burst bookkeeping.
// - Fairness: with all 4 inputs persistently requesting output j, grants rotate 0,1,2,3,0,...
// - No X on any output after reset; default branches drive 0.
// TESTING
// - Reset then idle: rst pulse, req_vld=0 -> all outputs 0, sel1..sel4=0 for 20 cycles.
// - Single burst: BURST_LEN=4, req_vld=4'b0001, dst0=2, out_rdy=1 at t -> t+1..t+4 out_vld[2]=1,
//   sel3=0, in_rdy[0]=1, in_last[0] only at t+4, IDLE at t+5.
// - RR fairness: all 4 inputs dst=1, out_rdy=1, held high -> sel2 sequence 0,1,2,3,0 per burst,
//   each burst 4 beats followed by one IDLE cycle; 4 grants in 20 cycles.
// - Parallel: inputs 0..3 -> dst 3,2,1,0 same cycle -> all 4 outputs BUSY t+1, sel1=3,sel2=2,
//   sel3=1,sel4=0; in_gnt=4'b1111.
// - Backpressure: single burst, out_rdy[j] low for cycles 2-3 of burst -> cnt holds, in_rdy=0
//   there, burst ends 2 cycles later, still exactly 4 in_rdy beats.
// - Async reset mid-burst: assert rst at cycle 2 of burst (between edges) -> out_vld, in_gnt drop
//   immediately; after release, pending req re-arbitrated with ptr=0.

Source files
------------

// File: rtl/crossbar4x4_sched.sv
`default_nettype none
// ============================================================================
//  Module   : crossbar4x4_sched
//  Purpose  : Round-robin burst scheduler for a 4x4 crossbar. Each of four
//             requesters names one destination output. Every output runs its
//             own IDLE/BUSY arbiter, grants one requester for BURST_LEN beats,
//             and then rotates priority to the next requester.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             req_vld[3:0]       - requester i wants a burst
//             req_dst[7:0]       - [2i+1:2i] destination output of requester i
//             out_rdy[3:0]       - output j sink accepts a beat this cycle
//             sel1..sel4[1:0]    - crossbar select (owning input) per output
//             out_vld[3:0]       - output j is carrying a granted burst
//             in_rdy[3:0]        - a beat from input i moves this cycle
//             in_last[3:0]       - that beat closes input i's burst
//             in_gnt[3:0]        - input i currently owns an output
//  Revision : 1.0 - initial release
// ============================================================================
module crossbar4x4_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_vld,
    input  logic [7:0] req_dst,
    input  logic [3:0] out_rdy,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic [1:0] sel3,
    output logic [1:0] sel4,
    output logic [3:0] out_vld,
    output logic [3:0] in_rdy,
    output logic [3:0] in_last,
    output logic [3:0] in_gnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_LAST_BEAT = 8'(BURST_LEN - 1);

    // Per-output state exported from the generate blocks
    logic [3:0] w_busy;
    logic [3:0] w_at_last;
    logic [1:0] w_own [4];

    // Handshake back to requesters: everything derives from registered owner
    // state plus the sink ready, so there is no path from req_* to these.
    always_comb begin
        in_gnt  = '0;
        in_rdy  = '0;
        in_last = '0;
        for (int j = 0; j < 4; j++) begin
            if (w_busy[j]) begin
                in_gnt[w_own[j]] = 1'b1;
                if (out_rdy[j]) begin
                    in_rdy[w_own[j]] = 1'b1;
                    if (w_at_last[j]) begin
                        in_last[w_own[j]] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_out
        state_t     r_state;
        logic [7:0] r_cnt;
        logic [1:0] r_ptr;
        logic [1:0] r_own;
        logic [3:0] w_elig;
        logic [1:0] w_win;
        logic [1:0] w_idx;

        // Inputs that already own an output are masked, so a requester that
        // retargets req_dst mid-burst cannot grab a second path.
        always_comb begin
            for (int i = 0; i < 4; i++) begin
                w_elig[i] = req_vld[i] & (req_dst[2*i +: 2] == 2'(j)) & ~in_gnt[i];
            end
        end

        // Scan from the farthest offset back to ptr so the closest eligible
        // input after the pointer is the one left standing.
        always_comb begin
            w_win = r_ptr;
            w_idx = r_ptr;
            for (int k = 3; k >= 0; k--) begin
                w_idx = r_ptr + 2'(k);
                if (w_elig[w_idx]) begin
                    w_win = w_idx;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_ptr   <= '0;
                r_own   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (|w_elig) begin
                            r_state <= S_BUSY;
                            r_own   <= w_win;
                            r_cnt   <= '0;
                            r_ptr   <= w_win + 2'd1;
                        end
                    end
                    S_BUSY: begin
                        // A stalled sink freezes the burst in place
                        if (out_rdy[j]) begin
                            if (r_cnt == c_LAST_BEAT) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_busy[j]    = (r_state == S_BUSY);
        assign w_at_last[j] = (r_cnt == c_LAST_BEAT);
        assign w_own[j]     = r_own;
    end

    // The select holds the last owner while idle
    assign sel1    = w_own[0];
    assign sel2    = w_own[1];
    assign sel3    = w_own[2];
    assign sel4    = w_own[3];
    assign out_vld = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_crossbar4x4_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crossbar4x4_sched
//  Purpose  : Directed bench for crossbar4x4_sched. Stimulus pushes expected
//             beats into a queue; a negedge monitor pops one per transferred
//             beat and checks source, destination and last flag. Timed
//             checks cover reset, grant latency, bubbles and backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crossbar4x4_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req_vld;
    logic [7:0] req_dst;
    logic [3:0] out_rdy;
    logic [1:0] sel1, sel2, sel3, sel4;
    logic [3:0] out_vld, in_rdy, in_last, in_gnt;

    // Single-beat instance sharing the same stimulus
    logic [1:0] s1_sel1, s1_sel2, s1_sel3, s1_sel4;
    logic [3:0] s1_out_vld, s1_in_rdy, s1_in_last, s1_in_gnt;

    logic [1:0] sel_a [4];

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic [1:0] src;
        logic [1:0] dst;
        logic       last;
    } beat_t;

    beat_t exp_q [$];

    crossbar4x4_sched #(.BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_dst(req_dst), .out_rdy(out_rdy),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
        .out_vld(out_vld), .in_rdy(in_rdy), .in_last(in_last), .in_gnt(in_gnt)
    );

    crossbar4x4_sched #(.BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_dst(req_dst), .out_rdy(out_rdy),
        .sel1(s1_sel1), .sel2(s1_sel2), .sel3(s1_sel3), .sel4(s1_sel4),
        .out_vld(s1_out_vld), .in_rdy(s1_in_rdy), .in_last(s1_in_last), .in_gnt(s1_in_gnt)
    );

    assign sel_a[0] = sel1;
    assign sel_a[1] = sel2;
    assign sel_a[2] = sel3;
    assign sel_a[3] = sel4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [1:0] src, input logic [1:0] dst);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{src: src, dst: dst, last: (b == 3)});
        end
    endtask

    // Monitor: one expected record per beat, outputs visited in ascending order
    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 4; j++) begin
                if (out_vld[j] && out_rdy[j]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat_out", 32'(j), 32'hFF);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_dst", 32'(j), 32'(e.dst));
                        check("beat_sel", 32'(sel_a[j]), 32'(e.src));
                        check("beat_in_rdy", 32'(in_rdy[e.src]), 32'd1);
                        check("beat_in_last", 32'(in_last[e.src]), 32'(e.last));
                    end
                end
            end
            if (|s1_in_rdy) begin
                check("len1_last_eq_rdy", 32'(s1_in_last), 32'(s1_in_rdy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req_vld  = '0;
        req_dst  = '0;
        out_rdy  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_outputs", 32'({sel1, sel2, sel3, sel4, out_vld, in_rdy, in_last, in_gnt}), 32'd0);
        end

        // Single burst: input 0 -> out3
        req_dst = 8'h02;
        req_vld = 4'b0001;
        out_rdy = 4'hF;
        push_burst(2'd0, 2'd2);
        tick();
        check("single_out_vld", 32'(out_vld), 32'h4);
        check("single_sel3", 32'(sel3), 32'd0);
        check("single_in_rdy", 32'(in_rdy), 32'h1);
        check("single_last_early", 32'(in_last), 32'h0);
        check("single_gnt", 32'(in_gnt), 32'h1);
        check("len1_last_first", 32'(s1_in_last), 32'h1);
        req_vld = 4'b0000;
        tick();
        check("single_in_rdy2", 32'(in_rdy), 32'h1);
        check("single_last2", 32'(in_last), 32'h0);
        check("len1_bubble", 32'(s1_out_vld), 32'h0);
        tick();
        check("single_last3", 32'(in_last), 32'h0);
        tick();
        check("single_last4", 32'(in_last), 32'h1);
        tick();
        check("single_idle", 32'(out_vld), 32'h0);

        // Round-robin: everyone targets out2
        req_dst = 8'h55;
        req_vld = 4'hF;
        for (int b = 0; b < 5; b++) push_burst(2'(b % 4), 2'd1);
        for (int b = 0; b < 5; b++) begin
            tick();
            check("rr_sel2", 32'(sel2), 32'(b % 4));
            check("rr_gnt", 32'(in_gnt), 32'(1 << (b % 4)));
            repeat (3) tick();
            if (b == 4) req_vld = 4'b0000;
            tick();
            check("rr_bubble", 32'(out_vld[1]), 32'd0);
        end

        // Parallel: inputs 0..3 -> outputs 4..1
        req_dst = 8'h1B;
        req_vld = 4'hF;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back('{src: 2'(3 - j), dst: 2'(j), last: (b == 3)});
            end
        end
        tick();
        check("par_out_vld", 32'(out_vld), 32'hF);
        check("par_sels", 32'({sel1, sel2, sel3, sel4}), 32'({2'd3, 2'd2, 2'd1, 2'd0}));
        check("par_gnt", 32'(in_gnt), 32'hF);
        req_vld = 4'b0000;
        repeat (3) tick();
        check("par_last", 32'(in_last), 32'hF);
        tick();
        check("par_idle", 32'(out_vld), 32'h0);

        // Backpressure: input 1 -> out1, sink stalls on burst cycles 2-3
        req_dst = 8'h00;
        req_vld = 4'b0010;
        push_burst(2'd1, 2'd0);
        tick();
        check("bp_rdy1", 32'(in_rdy), 32'h2);
        req_vld = 4'b0000;
        out_rdy = 4'b1110;
        tick();
        check("bp_stall2", 32'(in_rdy), 32'h0);
        check("bp_vld2", 32'(out_vld), 32'h1);
        tick();
        check("bp_stall3", 32'(in_rdy), 32'h0);
        out_rdy = 4'hF;
        tick();
        check("bp_rdy4", 32'(in_rdy), 32'h2);
        check("bp_last4", 32'(in_last), 32'h0);
        tick();
        tick();
        check("bp_last6", 32'(in_last), 32'h2);
        tick();
        check("bp_idle", 32'(out_vld), 32'h0);

        // Async reset mid-burst; out3 pointer is 2 so input 3 wins first
        req_dst = 8'h82;
        req_vld = 4'b1001;
        exp_q.push_back('{src: 2'd3, dst: 2'd2, last: 1'b0});
        tick();
        check("ar_sel3", 32'(sel3), 32'd3);
        check("ar_gnt", 32'(in_gnt), 32'h8);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("ar_vld_drop", 32'(out_vld), 32'h0);
        check("ar_gnt_drop", 32'(in_gnt), 32'h0);
        check("ar_rdy_drop", 32'(in_rdy), 32'h0);
        #2 rst = 1'b0;
        push_burst(2'd0, 2'd2);
        tick();
        check("ar_rearb_sel3", 32'(sel3), 32'd0);
        check("ar_rearb_gnt", 32'(in_gnt), 32'h1);
        req_vld = 4'b0000;
        repeat (3) tick();
        tick();
        check("ar_idle", 32'(out_vld), 32'h0);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
